obi_wb_arbiter: RTL
===================

Name: obi_wb_arbiter

Overview:
- Shares one Wishbone classic master port between the core's OBI instruction port and OBI data port.
- Used when ENABLE_SECOND_MEMORY is not defined, so both fetches and loads/stores must reach the Controller's single core_* bus.
- Converts OBI req/gnt/rvalid into Wishbone cyc/stb/ack, arbitrates round-robin and allows one outstanding transaction in total.
- Terminates hung bus cycles with an OBI error response after a timeout.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports; byte-enable width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, maximum cycles a Wishbone cycle may wait for ack; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_req_i  in  1  OBI instruction request.
- instr_gnt_o  out  1  OBI instruction grant.
- instr_addr_i  in  ADDR_WIDTH  fetch address.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  DATA_WIDTH  fetch data.
- instr_err_o  out  1  fetch bus error, valid with rvalid.
- data_req_i  in  1  OBI data request.
- data_gnt_o  out  1  OBI data grant.
- data_we_i  in  1  1 = write.
- data_be_i  in  DATA_WIDTH/8  byte enables.
- data_addr_i  in  ADDR_WIDTH  data address.
- data_wdata_i  in  DATA_WIDTH  write data.
- data_rvalid_o  out  1  data response valid.
- data_rdata_o  out  DATA_WIDTH  read data.
- data_err_o  out  1  data bus error, valid with rvalid.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write.
- wb_sel_o  out  DATA_WIDTH/8  Wishbone byte select.
- wb_addr_o  out  ADDR_WIDTH  Wishbone address.
- wb_data_o  out  DATA_WIDTH  Wishbone write data.
- wb_data_i  in  DATA_WIDTH  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- busy_o  out  1  high whenever state is not IDLE.
- timeout_o  out  1  one-cycle pulse when a timeout fires.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; last_owner=DATA; all outputs 0, including wb_* address/data registers and the rdata registers.
  - A reset mid-transaction drops cyc/stb immediately and never emits the pending rvalid.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - Winner selection: if only one req is high, that port wins. If both are high, the port that is not last_owner wins.
  - The winner's gnt is asserted combinationally in the same cycle as its req. gnt is 0 in every other state and to the loser.
  - On grant, register owner, addr, we, sel and wdata; last_owner<=owner; go to BUS.
  - Instruction grants register we=0 and sel=all ones.
  - No req: stay in IDLE.
- BUS:
  - wb_cyc_o=wb_stb_o=1; wb_we/sel/addr/data driven from the registers captured at grant, held stable.
  - On wb_ack_i=1: capture wb_data_i into the owner's rdata (writes capture it too, value unspecified to the core); err<=0; go to RESP.
  - Timeout: counter starts at 0 on BUS entry and increments each BUS cycle without ack. If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with no ack, go to RESP with err<=1 and pulse timeout_o. cyc/stb are low in the following cycle.
  - An ack arriving in the same cycle as the timeout limit wins: normal response, no error.
  - wb_ack_i outside BUS is ignored.
- RESP:
  - The owner's rvalid is 1 for exactly one cycle, with rdata and err. The other port's rvalid is 0.
  - Next state is IDLE; no grant is issued in RESP.
  - rdata outputs hold their value until the next capture.
- Latency: grant at cycle 0, stb high from cycle 1, ack in cycle k ≥ 1, rvalid in cycle k+1. Minimum 3 cycles per transfer.
- OBI rules:
  - rvalid is never in the same cycle as gnt.
  - Requesters hold req and attributes until gnt; attributes are sampled only at gnt.
  - Responses return in grant order, which is trivial with one outstanding transaction.
- Counter width is clog2(TIMEOUT_CYCLES+1) and the counter never wraps.

Test Plan:
- Single fetch: instr_req=1, addr=0x1000; slave acks one cycle after stb with 0x00000013 -> gnt in cycle 0, wb_addr=0x1000, wb_sel=0xF, wb_we=0, instr_rvalid=1 with rdata=0x00000013 and err=0 in cycle 3.
- Data write: data_req=1, we=1, be=0x3, addr=0x2004, wdata=0xDEADBEEF -> wb_we=1, wb_sel=0x3, wb_data=0xDEADBEEF held until ack; data_rvalid one cycle after ack; instr_rvalid stays 0.
- Simultaneous requests after reset, both held continuously -> grant order instr, data, instr, data; never two gnt in one cycle; busy_o low only in the IDLE cycles between transfers.
- Timeout: TIMEOUT_CYCLES=8, no ack -> stb high for exactly 8 cycles, then timeout_o pulse; data_rvalid=1 with data_err=1 next cycle, cyc=0. Also ack in the 8th cycle -> err=0.
- Reset mid-transfer: assert rst_n=0 while in BUS -> wb_cyc/stb drop asynchronously; no rvalid after release; the next request is granted normally with instr winning a tie.

Source files
------------

// File: rtl/obi_wb_arbiter_if.sv
// Bus bundle between the core's two OBI ports, the arbiter and the Wishbone side.
// The slave modport is the arbiter's view; master is the core + Wishbone slave.
interface obi_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic                  instr_req_i;
  logic                  instr_gnt_o;
  logic [ADDR_WIDTH-1:0] instr_addr_i;
  logic                  instr_rvalid_o;
  logic [DATA_WIDTH-1:0] instr_rdata_o;
  logic                  instr_err_o;

  logic                  data_req_i;
  logic                  data_gnt_o;
  logic                  data_we_i;
  logic [BE_W-1:0]       data_be_i;
  logic [ADDR_WIDTH-1:0] data_addr_i;
  logic [DATA_WIDTH-1:0] data_wdata_i;
  logic                  data_rvalid_o;
  logic [DATA_WIDTH-1:0] data_rdata_o;
  logic                  data_err_o;

  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [BE_W-1:0]       wb_sel_o;
  logic [ADDR_WIDTH-1:0] wb_addr_o;
  logic [DATA_WIDTH-1:0] wb_data_o;
  logic [DATA_WIDTH-1:0] wb_data_i;
  logic                  wb_ack_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  wb_data_i, wb_ack_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output wb_data_i, wb_ack_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o
  );
endinterface

// File: rtl/obi_wb_arbiter.sv
// Round-robin arbiter folding OBI instr + data ports onto one Wishbone classic
// master, one outstanding transfer total, with an ack timeout that errors out.
module obi_wb_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  obi_wb_arbiter_if.slave  bus,
  output logic             busy_o,
  output logic             timeout_o
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  typedef struct packed {
    logic                  we;
    logic [BE_W-1:0]       sel;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } wb_req_t;

  state_e                     state_q, state_d;
  logic                       owner_q, last_owner_q;
  wb_req_t                    req_q, grant_req;
  logic [CNT_W-1:0]           cnt_q;
  logic [1:0][DATA_WIDTH-1:0] rdata_q;
  logic                       err_q;
  logic                       instr_win, data_win, ack_hit, to_hit;
  logic [1:0]                 rvalid, rerr;

  // Next state, winner selection and bus-cycle termination
  always_comb begin
    state_d   = state_q;
    instr_win = 1'b0;
    data_win  = 1'b0;
    ack_hit   = 1'b0;
    to_hit    = 1'b0;
    case (state_q)
      IDLE: begin
        instr_win = bus.instr_req_i && (!bus.data_req_i || last_owner_q == OWN_D);
        data_win  = bus.data_req_i && !instr_win;
        if (instr_win || data_win) state_d = BUS;
      end
      BUS: begin
        ack_hit = bus.wb_ack_i;
        // ack on the limit cycle takes priority over the timeout
        to_hit  = !bus.wb_ack_i && (TIMEOUT_CYCLES != 0) &&
                  (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        if (ack_hit || to_hit) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Attributes captured at grant; fetches are always full-word reads
  always_comb begin
    grant_req = '{we: 1'b0, sel: '1, addr: bus.instr_addr_i, wdata: '0};
    if (data_win)
      grant_req = '{we: bus.data_we_i, sel: bus.data_be_i,
                    addr: bus.data_addr_i, wdata: bus.data_wdata_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_D;
      req_q        <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (instr_win || data_win) begin
            owner_q      <= data_win;
            last_owner_q <= data_win;
            req_q        <= grant_req;
            cnt_q        <= '0;
          end
        end
        BUS: begin
          if (ack_hit) begin
            rdata_q[owner_q] <= bus.wb_data_i;
            err_q            <= 1'b0;
          end else if (to_hit) begin
            err_q <= 1'b1;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign rvalid[p] = (state_q == RESP) && (owner_q == 1'(p));
    assign rerr[p]   = rvalid[p] && err_q;
  end

  assign bus.instr_gnt_o    = instr_win;
  assign bus.data_gnt_o     = data_win;
  assign bus.instr_rvalid_o = rvalid[OWN_I];
  assign bus.data_rvalid_o  = rvalid[OWN_D];
  assign bus.instr_err_o    = rerr[OWN_I];
  assign bus.data_err_o     = rerr[OWN_D];
  assign bus.instr_rdata_o  = rdata_q[OWN_I];
  assign bus.data_rdata_o   = rdata_q[OWN_D];

  // cyc/stb decode straight from the async-reset state so reset kills them at once
  assign bus.wb_cyc_o  = (state_q == BUS);
  assign bus.wb_stb_o  = (state_q == BUS);
  assign bus.wb_we_o   = req_q.we;
  assign bus.wb_sel_o  = req_q.sel;
  assign bus.wb_addr_o = req_q.addr;
  assign bus.wb_data_o = req_q.wdata;

  assign busy_o    = (state_q != IDLE);
  assign timeout_o = to_hit;
endmodule
